// File: rtl/clk_pulse_gen.sv
// clk_pulse_gen: programmable clock/pulse generator. Period and high time
// are counted in system-clock cycles. New settings are staged in a shadow
// register and only take effect at a period boundary, so no shortened high
// or low phase is ever produced.
//
// Parameter legality (2 <= DEF_PERIOD <= 2^CNT_W-1, 1 <= DEF_HIGH < DEF_PERIOD)
// is the integrator's responsibility; nothing here checks it at runtime.
//
// Config handshake: cfg_wr is a single-cycle strobe with no back-pressure.
// A legal write is always accepted into the shadow (last write wins). An
// illegal one is dropped and answered by a one-cycle cfg_err.
module clk_pulse_gen #(
  parameter int CNT_W      = 8,
  parameter int DEF_PERIOD = 10,
  parameter int DEF_HIGH   = 5
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic             cfg_wr,
  input  logic [CNT_W-1:0] cfg_period,
  input  logic [CNT_W-1:0] cfg_high,
  output logic             clk_out,
  output logic             rise_pulse,
  output logic             fall_pulse,
  output logic             busy,
  output logic             cfg_pending,
  output logic             cfg_err
);

  typedef enum logic {
    IDLE = 1'b0,
    RUN  = 1'b1
  } state_t;

  state_t           state, state_nx;
  logic [CNT_W-1:0] ph, ph_nx;
  logic [CNT_W-1:0] act_period, act_period_nx;
  logic [CNT_W-1:0] act_high, act_high_nx;
  logic [CNT_W-1:0] shd_period, shd_period_nx;
  logic [CNT_W-1:0] shd_high, shd_high_nx;
  logic             pending_nx;
  logic             clk_out_nx, rise_nx, fall_nx, err_nx;
  logic             wr_valid;
  logic             wrap;
  logic             apply;

  // busy is a direct decode of the state register, so reset clears it at once.
  assign busy = (state == RUN);

  // State, counter, config and registered outputs; async reset returns to defaults.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state       <= IDLE;
      ph          <= '0;
      act_period  <= CNT_W'(DEF_PERIOD);
      act_high    <= CNT_W'(DEF_HIGH);
      shd_period  <= '0;
      shd_high    <= '0;
      cfg_pending <= 1'b0;
      clk_out     <= 1'b0;
      rise_pulse  <= 1'b0;
      fall_pulse  <= 1'b0;
      cfg_err     <= 1'b0;
    end else begin
      state       <= state_nx;
      ph          <= ph_nx;
      act_period  <= act_period_nx;
      act_high    <= act_high_nx;
      shd_period  <= shd_period_nx;
      shd_high    <= shd_high_nx;
      cfg_pending <= pending_nx;
      clk_out     <= clk_out_nx;
      rise_pulse  <= rise_nx;
      fall_pulse  <= fall_nx;
      cfg_err     <= err_nx;
    end
  end

  // Next-state, phase advance, shadow apply and next output values.
  always_comb begin
    state_nx      = state;
    ph_nx         = ph;
    act_period_nx = act_period;
    act_high_nx   = act_high;
    shd_period_nx = shd_period;
    shd_high_nx   = shd_high;
    pending_nx    = cfg_pending;
    clk_out_nx    = 1'b0;
    rise_nx       = 1'b0;
    fall_nx       = 1'b0;
    apply         = 1'b0;

    wr_valid = cfg_wr && (cfg_period >= CNT_W'(2)) && (cfg_high != '0) &&
               (cfg_high < cfg_period);
    err_nx   = cfg_wr && !wr_valid;
    wrap     = (ph == act_period - 1'b1);

    case (state)
      IDLE: begin
        // Nothing is running, so a staged config can go live right away.
        apply = cfg_pending;
        if (en) begin
          state_nx   = RUN;
          ph_nx      = '0;
          clk_out_nx = 1'b1;
          rise_nx    = 1'b1;
        end
      end
      RUN: begin
        if (wrap) begin
          // Period boundary: the only point where config changes or a stop lands.
          ph_nx = '0;
          apply = cfg_pending;
          if (!en) begin
            state_nx = IDLE;
          end else begin
            // High time is always >= 1, so phase 0 is high under any config.
            clk_out_nx = 1'b1;
            rise_nx    = 1'b1;
          end
        end else begin
          ph_nx      = ph + 1'b1;
          clk_out_nx = (ph_nx < act_high);
          fall_nx    = (ph_nx == act_high);
        end
      end
      default: begin
        state_nx = IDLE;
        ph_nx    = '0;
      end
    endcase

    if (apply) begin
      act_period_nx = shd_period;
      act_high_nx   = shd_high;
      pending_nx    = 1'b0;
    end

    // A write landing on the apply cycle is staged for the next boundary.
    if (wr_valid) begin
      shd_period_nx = cfg_period;
      shd_high_nx   = cfg_high;
      pending_nx    = 1'b1;
    end
  end

endmodule

// File: tb/tb_clk_pulse_gen.sv
// tb_clk_pulse_gen: directed bench for clk_pulse_gen. A behavioural phase
// model tracks the expected waveform; directed steps cover default run,
// reconfiguration, rejected writes, graceful stop, async reset and the
// minimum period.
module tb_clk_pulse_gen;

  logic       clk;
  logic       rst;
  logic       en;
  logic       cfg_wr;
  logic [7:0] cfg_period;
  logic [7:0] cfg_high;
  logic       clk_out;
  logic       rise_pulse;
  logic       fall_pulse;
  logic       busy;
  logic       cfg_pending;
  logic       cfg_err;

  int checks = 0;
  int errors = 0;

  // Expected-behaviour model state
  logic       exp_run;
  int         exp_ph;
  int         exp_p, exp_h;
  int         nxt_p, nxt_h;
  logic       pend_m;
  logic       err_m;

  clk_pulse_gen #(.CNT_W(8), .DEF_PERIOD(10), .DEF_HIGH(5)) dut (
    .clk         (clk),
    .rst         (rst),
    .en          (en),
    .cfg_wr      (cfg_wr),
    .cfg_period  (cfg_period),
    .cfg_high    (cfg_high),
    .clk_out     (clk_out),
    .rise_pulse  (rise_pulse),
    .fall_pulse  (fall_pulse),
    .busy        (busy),
    .cfg_pending (cfg_pending),
    .cfg_err     (cfg_err)
  );

  // Clock
  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic got, input logic want);
    checks++;
    assert (got === want) else begin
      errors++;
      $error("FAIL %s got %b exp %b at %0t", tag, got, want, $time);
    end
  endtask

  task automatic model_reset();
    exp_run = 1'b0;
    exp_ph  = 0;
    exp_p   = 10;
    exp_h   = 5;
    nxt_p   = 0;
    nxt_h   = 0;
    pend_m  = 1'b0;
    err_m   = 1'b0;
  endtask

  // One clock edge: advance the model from the inputs seen at the edge, then compare.
  task automatic tick_check();
    logic en_s, wr_s, valid_s;
    int   wp, wh;
    en_s    = en;
    wr_s    = cfg_wr;
    wp      = int'(cfg_period);
    wh      = int'(cfg_high);
    valid_s = wr_s && (wp >= 2) && (wh >= 1) && (wh < wp);
    @(posedge clk);
    #1;
    if (exp_run) begin
      if (exp_ph == exp_p - 1) begin
        exp_ph = 0;
        if (pend_m) begin exp_p = nxt_p; exp_h = nxt_h; pend_m = 1'b0; end
        if (!en_s) exp_run = 1'b0;
      end else begin
        exp_ph = exp_ph + 1;
      end
    end else begin
      if (pend_m) begin exp_p = nxt_p; exp_h = nxt_h; pend_m = 1'b0; end
      if (en_s) begin exp_run = 1'b1; exp_ph = 0; end
    end
    if (valid_s) begin nxt_p = wp; nxt_h = wh; pend_m = 1'b1; end
    err_m = wr_s && !valid_s;
    chk("busy",        busy,        exp_run);
    chk("clk_out",     clk_out,     exp_run && (exp_ph < exp_h));
    chk("rise_pulse",  rise_pulse,  exp_run && (exp_ph == 0));
    chk("fall_pulse",  fall_pulse,  exp_run && (exp_ph == exp_h));
    chk("cfg_pending", cfg_pending, pend_m);
    chk("cfg_err",     cfg_err,     err_m);
  endtask

  task automatic run_ticks(input int n);
    for (int i = 0; i < n; i++) tick_check();
  endtask

  task automatic run_to_ph(input int target);
    for (int i = 0; i < 300 && !(exp_run && exp_ph == target); i++) tick_check();
  endtask

  task automatic do_write(input int p, input int h);
    cfg_period = 8'(p);
    cfg_high   = 8'(h);
    cfg_wr     = 1'b1;
    tick_check();
    cfg_wr     = 1'b0;
    cfg_period = 8'd0;
    cfg_high   = 8'd0;
  endtask

  initial begin
    rst        = 1'b1;
    en         = 1'b0;
    cfg_wr     = 1'b0;
    cfg_period = 8'd0;
    cfg_high   = 8'd0;
    model_reset();

    // Reset state
    #12;
    chk("rst_clk_out",  clk_out,     1'b0);
    chk("rst_busy",     busy,        1'b0);
    chk("rst_rise",     rise_pulse,  1'b0);
    chk("rst_fall",     fall_pulse,  1'b0);
    chk("rst_pending",  cfg_pending, 1'b0);
    chk("rst_err",      cfg_err,     1'b0);
    rst = 1'b0;
    run_ticks(2);

    // Default 10/5 run: first high one cycle after en
    en = 1'b1;
    tick_check();
    chk("first_high", clk_out,    1'b1);
    chk("first_rise", rise_pulse, 1'b1);
    run_ticks(4);
    chk("still_high_ph4", clk_out, 1'b1);
    tick_check();
    chk("fall_at_ph5", fall_pulse, 1'b1);
    chk("low_at_ph5",  clk_out,    1'b0);
    run_ticks(4);
    tick_check();
    chk("rise_after_10", rise_pulse, 1'b1);
    run_ticks(15);

    // Reconfigure mid-run: period 4 / high 1 written at ph 2
    run_to_ph(2);
    do_write(4, 1);
    chk("reconf_pending", cfg_pending, 1'b1);
    run_ticks(20);
    chk("reconf_applied", cfg_pending, 1'b0);

    // Rejected writes, each separately
    do_write(1, 0);
    chk("inv1_err", cfg_err, 1'b1);
    run_ticks(5);
    do_write(6, 6);
    chk("inv2_err", cfg_err, 1'b1);
    run_ticks(5);
    do_write(6, 0);
    chk("inv3_err", cfg_err, 1'b1);
    tick_check();
    chk("inv3_err_one_cycle", cfg_err, 1'b0);
    run_ticks(6);

    // Back to 10/5, then graceful stop at ph 2
    do_write(10, 5);
    run_ticks(12);
    run_to_ph(2);
    en = 1'b0;
    run_ticks(7);
    chk("stop_last_low_busy", busy, 1'b1);
    tick_check();
    chk("stop_idle_busy", busy,    1'b0);
    chk("stop_idle_clk",  clk_out, 1'b0);
    run_ticks(4);
    en = 1'b1;
    tick_check();
    chk("restart_rise", rise_pulse, 1'b1);
    chk("restart_high", clk_out,    1'b1);
    run_ticks(12);

    // Async reset in the middle of a high phase, with 6/2 active
    do_write(6, 2);
    run_ticks(14);
    run_to_ph(0);
    #3;
    rst = 1'b1;
    #1;
    chk("arst_clk_out", clk_out,     1'b0);
    chk("arst_busy",    busy,        1'b0);
    chk("arst_rise",    rise_pulse,  1'b0);
    chk("arst_fall",    fall_pulse,  1'b0);
    chk("arst_pending", cfg_pending, 1'b0);
    #1;
    rst = 1'b0;
    en  = 1'b0;
    model_reset();
    run_ticks(2);
    en = 1'b1;
    run_ticks(25);

    // Minimum config 2/1
    do_write(2, 1);
    run_ticks(14);
    en = 1'b0;
    run_ticks(4);
    chk("min_stopped", busy, 1'b0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
